result_ram_drain: RTL and testbench

//   Reads back a contiguous window of the result RAM after the systolic cube has

---
 rtl/result_ram_drain_if.sv | 28 ++
 rtl/result_ram_drain.sv | 124 ++++++++++++
 tb/tb_result_ram_drain.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/result_ram_drain_if.sv
// Control, result-RAM read port and output stream of the result RAM drain.
interface result_ram_drain_if #(
  parameter int AW         = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [AW-1:0]         base_addr;
  logic [AW:0]           length;
  logic                  busy;
  logic                  done;
  logic                  ram_rd_en;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (
    input  start, base_addr, length, ram_data, ready,
    output busy, done, ram_rd_en, ram_addr, valid, data, last
  );

  modport slave (
    output start, base_addr, length, ram_data, ready,
    input  busy, done, ram_rd_en, ram_addr, valid, data, last
  );
endinterface

// File: rtl/result_ram_drain.sv
// Reads a contiguous (wrapping) window of the result RAM and streams it out on
// valid/ready, with a 2-entry buffer absorbing sink backpressure.
module result_ram_drain #(
  parameter int RAM_DEPTH  = 2048,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  result_ram_drain_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start
  // READ  | issuing RAM reads while the buffer has credit
  // DRAIN | all reads issued; emptying buffer until the last word is accepted
  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
  localparam logic [AW:0]   ONE_CNT   = (AW+1)'(1);

  logic [1:0]            state;
  logic [AW-1:0]         addr;
  logic [AW:0]           len;
  logic [AW:0]           issued;
  logic [AW:0]           popped;
  logic                  inflight;
  logic                  done;
  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic       pop;
  logic       push;
  logic       rd_en;
  logic       last_word;
  logic [2:0] occupancy;

  assign pop       = (count != 2'd0) && bus.ready;
  assign push      = inflight;
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  // A read is allowed only if its word is guaranteed a buffer slot on arrival.
  assign rd_en     = (state == READ) && (issued != len) &&
                     (occupancy < (3'd2 + {2'b00, pop}));
  assign last_word = (popped == (len - ONE_CNT));

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.ram_rd_en = rd_en;
  assign bus.ram_addr  = addr;
  assign bus.valid     = (count != 2'd0);
  assign bus.data      = buf_mem[rd_ptr];
  assign bus.last      = (count != 2'd0) && last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      len      <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= rd_en;
      if (rd_en) begin
        addr   <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        issued <= issued + ONE_CNT;
      end
      if (pop) begin
        popped <= popped + ONE_CNT;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.length != '0) begin
              state  <= READ;
              addr   <= bus.base_addr;
              len    <= bus.length;
              issued <= '0;
              popped <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_en && ((issued + ONE_CNT) == len)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && last_word) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lands in the buffer the cycle after its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= bus.ram_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_result_ram_drain.sv
// Self-checking bench for result_ram_drain: table vectors, random drains
// against a stream model, and a mid-drain reset sequence.
module tb_result_ram_drain;
  localparam int RAM_DEPTH = 2048;
  localparam int DW        = 32;
  localparam int AW        = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_ram_drain_if #(.AW(AW), .DATA_WIDTH(DW)) bus ();
  result_ram_drain #(.RAM_DEPTH(RAM_DEPTH), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] ram [RAM_DEPTH];
  always @(posedge clk) if (bus.ram_rd_en) bus.ram_data <= ram[bus.ram_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // sink ready generator: 0 = always, 1 = pattern 1,0,0 repeating, 2 = random
  int ready_mode = 0;
  int rcyc = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.ready = 1'b1;
      1:       bus.ready = ((rcyc % 3) == 0);
      default: bus.ready = 1'($urandom_range(0, 1));
    endcase
    rcyc++;
  end

  // stream monitor; k = 0 is the cycle right after the start edge
  bit            mon_en = 0;
  int            k, first_valid_k, busy_cycles, done_k, n_done, n_reads, n_pops, exp_base;
  bit            stall_prev;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  logic [DW-1:0] got_data[$];
  logic          got_last[$];

  always @(negedge clk) if (mon_en) begin
    if (bus.ram_rd_en) begin
      chk("rd_addr", 64'(bus.ram_addr), 64'((exp_base + n_reads) % RAM_DEPTH));
      chk("rd_credit", 64'((n_reads - n_pops - ((bus.valid && bus.ready) ? 1 : 0)) < 2), 64'd1);
      n_reads++;
    end
    if (stall_prev) begin
      chk("stall_valid", 64'(bus.valid), 64'd1);
      chk("stall_data", 64'(bus.data), 64'(stall_data));
      chk("stall_last", 64'(bus.last), 64'(stall_last));
    end
    stall_prev = bus.valid && !bus.ready;
    stall_data = bus.data;
    stall_last = bus.last;
    if (bus.valid && first_valid_k < 0) first_valid_k = k;
    if (bus.valid && bus.ready) begin
      got_data.push_back(bus.data);
      got_last.push_back(bus.last);
      n_pops++;
    end
    if (bus.busy) busy_cycles++;
    if (bus.done) begin
      n_done++;
      if (done_k < 0) done_k = k;
    end
    k++;
  end

  task automatic start_drain(input int base, input int len, input int mode);
    ready_mode = mode;
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.length    = (AW+1)'(len);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    k = 0; first_valid_k = -1; busy_cycles = 0; done_k = -1;
    n_done = 0; n_reads = 0; n_pops = 0; exp_base = base; stall_prev = 0;
    got_data.delete();
    got_last.delete();
    mon_en = 1;
  endtask

  // expected stream: word i = ram[(base+i) mod depth], last only on word len-1
  task automatic check_stream(input string tag, input int base, input int len);
    chk({tag, "_count"}, 64'(got_data.size()), 64'(len));
    chk({tag, "_reads"}, 64'(n_reads), 64'(len));
    for (int i = 0; i < got_data.size() && i < len; i++) begin
      chk({tag, "_data"}, 64'(got_data[i]), 64'(ram[(base + i) % RAM_DEPTH]));
      chk({tag, "_last"}, 64'(got_last[i]), 64'(i == len - 1));
    end
  endtask

  task automatic run_drain(input string tag, input int base, input int len, input int mode,
                           input int exp_done_k, input int exp_fv_k, input bit restart);
    start_drain(base, len, mode);
    for (int t = 0; t < len * 8 + 50 && n_done == 0; t++) begin
      @(posedge clk);
      #1;
      bus.start = restart && (t == 2);
      if (bus.start) begin
        bus.base_addr = AW'(base ^ 'h155);
        bus.length    = (AW+1)'(5);
      end
    end
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mon_en = 0;
    chk({tag, "_done_cnt"}, 64'(n_done), 64'd1);
    check_stream(tag, base, len);
    if (exp_done_k >= 0) chk({tag, "_done_k"}, 64'(done_k), 64'(exp_done_k));
    if (exp_fv_k >= 0)   chk({tag, "_first_valid_k"}, 64'(first_valid_k), 64'(exp_fv_k));
    if (len == 0) begin
      chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd0);
      chk({tag, "_no_valid"}, 64'(first_valid_k), 64'(-1));
      chk({tag, "_done_early"}, 64'(done_k >= 0 && done_k <= 1), 64'd1);
    end else if (mode == 0) begin
      chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(len + 2));
    end
  endtask

  typedef struct {
    int base;
    int len;
    int mode;
    int exp_done_k;
    int exp_fv_k;
    bit restart;
  } vec_t;

  vec_t vecs[8];

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_rd_en"}, 64'(bus.ram_rd_en), 64'd0);
    chk({tag, "_addr"}, 64'(bus.ram_addr), 64'd0);
    chk({tag, "_valid"}, 64'(bus.valid), 64'd0);
    chk({tag, "_last"}, 64'(bus.last), 64'd0);
    chk({tag, "_data"}, 64'(bus.data), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
    bus.ready = 1'b1; bus.ram_data = '0;
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = DW'(i);
    #1;
    check_idle_outputs("reset");
    #21;
    rst_n = 1'b1;

    // first valid: read at k=0, RAM data at k=1, buffered and visible at k=2
    vecs[0] = '{0,    4,    0, 6,    2, 1'b0};
    vecs[1] = '{2046, 4,    0, 6,    2, 1'b0};
    vecs[2] = '{5,    8,    1, -1,   2, 1'b0};
    vecs[3] = '{0,    0,    0, -1,   -1, 1'b0};
    vecs[4] = '{300,  12,   0, 14,   2, 1'b1};
    vecs[5] = '{1000, 1,    0, 3,    2, 1'b0};
    vecs[6] = '{1,    2048, 0, 2050, 2, 1'b0};
    vecs[7] = '{2040, 20,   2, -1,   2, 1'b0};
    for (int v = 0; v < 8; v++)
      run_drain($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].mode,
                vecs[v].exp_done_k, vecs[v].exp_fv_k, vecs[v].restart);

    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = $urandom;
    for (int r = 0; r < 25; r++) begin
      int b, l, m;
      bit rs;
      b  = $urandom_range(0, RAM_DEPTH - 1);
      l  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : $urandom_range(7, 60);
      m  = $urandom_range(0, 2);
      rs = (l >= 8) && ($urandom_range(0, 1) == 1);
      run_drain($sformatf("rnd%0d", r), b, l, m, (m == 0 && l > 0) ? l + 2 : -1,
                (l > 0) ? 2 : -1, rs);
    end

    // reset after 3 of 10 words
    start_drain(50, 10, 0);
    for (int t = 0; t < 40 && n_pops < 3; t++) @(posedge clk);
    chk("rst_pops_reached", 64'(n_pops >= 3), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    mon_en = 0;
    chk("rst_no_done", 64'(n_done), 64'd0);
    chk("rst_stays_idle", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 3 && i < got_data.size(); i++)
      chk("rst_pre_data", 64'(got_data[i]), 64'(ram[50 + i]));
    run_drain("post_rst", 700, 2, 0, 4, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
